link_arbiter: RTL and testbench

- Schedules four router output channels onto one shared 43-bit downstream link.
- Each channel has a one-entry holding buffer with a valid/ready handshake.
- The highest effective priority wins. Ties go round-robin. Aging stops starvation.
- Sits directly downstream of the router's channel_1..channel_4 outputs.

---
 rtl/link_arbiter.sv | 128 ++++++++++++
 tb/tb_link_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/link_arbiter.sv
// Four-channel link arbiter: one-entry buffers per channel, priority with
// round-robin tie-break and age-based promotion onto a single output link.
module link_arbiter #(
    parameter int PKT_W   = 43,
    parameter int AGE_W   = 4,
    parameter int AGE_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] channel_1_in,
    input  logic [PKT_W-1:0] channel_2_in,
    input  logic [PKT_W-1:0] channel_3_in,
    input  logic [PKT_W-1:0] channel_4_in,
    input  logic [3:0]       ch_valid,
    output logic [3:0]       ch_ready,
    input  logic             out_ready,
    output logic [PKT_W-1:0] out_data,
    output logic             out_valid,
    output logic [1:0]       grant_id,
    output logic [15:0]      pkt_count
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    logic [3:0]       full;
    logic [PKT_W-1:0] pbuf  [4];
    logic [PKT_W-1:0] pin   [4];
    logic [AGE_W-1:0] age   [4];
    logic [2:0]       eprio [4];
    logic [1:0]       rr_ptr;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic [2:0]       best;
    logic             found;
    logic             load;
    logic [3:0]       win_mask;

    assign pin[0]   = channel_1_in;
    assign pin[1]   = channel_2_in;
    assign pin[2]   = channel_3_in;
    assign pin[3]   = channel_4_in;
    assign ch_ready = ~full;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (age[i] == AGE_W'(AGE_MAX))
                eprio[i] = 3'd7;
            else
                eprio[i] = pbuf[i][PKT_W-1 -: 3];
        end
    end

    // Scan from rr_ptr+1; strict '>' keeps the earliest channel on ties.
    always_comb begin
        win   = rr_ptr;
        idx   = '0;
        best  = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (full[idx] && (!found || eprio[idx] > best)) begin
                found = 1'b1;
                best  = eprio[idx];
                win   = idx;
            end
        end
    end

    assign load     = (|full) && (state == IDLE || out_ready);
    assign win_mask = load ? (4'b0001 << win) : 4'b0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            full      <= '0;
            rr_ptr    <= 2'd3;
            out_data  <= '0;
            out_valid <= 1'b0;
            grant_id  <= '0;
            pkt_count <= '0;
            for (int i = 0; i < 4; i++) begin
                pbuf[i] <= '0;
                age[i]  <= '0;
            end
        end else begin
            full <= (full & ~win_mask) | (ch_valid & ~full);
            for (int i = 0; i < 4; i++) begin
                if (ch_valid[i] && !full[i]) begin
                    pbuf[i] <= pin[i];
                    age[i]  <= '0;
                end else if (load && full[i] && win != 2'(i)
                             && age[i] != AGE_W'(AGE_MAX)) begin
                    age[i] <= age[i] + AGE_W'(1);
                end
            end
            unique case (state)
                IDLE: begin
                    if (load) begin
                        out_data  <= pbuf[win];
                        grant_id  <= win;
                        rr_ptr    <= win;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        pkt_count <= pkt_count + 16'd1;
                        if (load) begin
                            out_data <= pbuf[win];
                            grant_id <= win;
                            rr_ptr   <= win;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_link_arbiter.sv
// Directed bench for link_arbiter: handshake, priority, round-robin,
// aging, stall and mid-transfer reset.
module tb_link_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [42:0] c1 = '0, c2 = '0, c3 = '0, c4 = '0;
    logic [3:0]  ch_valid = '0;
    logic [3:0]  ch_ready;
    logic        out_ready = 1'b0;
    logic [42:0] out_data;
    logic        out_valid;
    logic [1:0]  grant_id;
    logic [15:0] pkt_count;

    int errors = 0;
    int checks = 0;

    link_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .channel_1_in (c1),
        .channel_2_in (c2),
        .channel_3_in (c3),
        .channel_4_in (c4),
        .ch_valid     (ch_valid),
        .ch_ready     (ch_ready),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .grant_id     (grant_id),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [42:0] pkt(input logic [2:0] p,
                                        input logic [39:0] pl);
        return {p, pl};
    endfunction

    task automatic drain_wait(input string tag);
        int n = 0;
        while (out_valid === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 64'(out_valid), 64'd0);
    endtask

    logic [42:0] p1;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ch_ready", 64'(ch_ready), 64'hf);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        rst = 1'b1;

        // Single packet on channel 1
        p1 = pkt(3'd2, {8'd170, 8'd153, 8'd26, 8'd104, 8'd1});
        c1 = p1;
        ch_valid = 4'b0001;
        out_ready = 1'b1;
        tick();
        ch_valid = 4'b0000;
        chk("t1_ready_busy", 64'(ch_ready), 64'he);
        chk("t1_valid_early", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'(p1));
        chk("t1_grant", 64'(grant_id), 64'd0);
        chk("t1_ready_back", 64'(ch_ready), 64'hf);
        tick();
        chk("t1_count", 64'(pkt_count), 64'd1);
        chk("t1_idle", 64'(out_valid), 64'd0);

        // Strict priority ordering 1,2,0,3
        c1 = pkt(3'd1, 40'h1);
        c2 = pkt(3'd4, 40'h2);
        c3 = pkt(3'd2, 40'h3);
        c4 = pkt(3'd0, 40'h4);
        ch_valid = 4'b1111;
        tick();
        ch_valid = 4'b0000;
        tick();
        chk("t2_grant0", 64'(grant_id), 64'd1);
        chk("t2_valid", 64'(out_valid), 64'd1);
        tick();
        chk("t2_grant1", 64'(grant_id), 64'd2);
        tick();
        chk("t2_grant2", 64'(grant_id), 64'd0);
        tick();
        chk("t2_grant3", 64'(grant_id), 64'd3);
        chk("t2_data3", 64'(out_data), 64'(pkt(3'd0, 40'h4)));
        tick();
        chk("t2_idle", 64'(out_valid), 64'd0);
        chk("t2_count", 64'(pkt_count), 64'd5);

        // Round-robin among equal priorities
        c1 = pkt(3'd3, 40'h10);
        c2 = pkt(3'd3, 40'h11);
        c3 = pkt(3'd3, 40'h12);
        c4 = pkt(3'd3, 40'h13);
        ch_valid = 4'b1111;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t3_rr_grant", 64'(grant_id), 64'(k % 4));
        end
        ch_valid = 4'b0000;
        drain_wait("t3_drain");
        chk("t3_count", 64'(pkt_count), 64'd16);

        // Aging: low-priority channel 4 against refilled prio-4 traffic
        c1 = pkt(3'd4, 40'h20);
        c2 = pkt(3'd4, 40'h21);
        c3 = pkt(3'd4, 40'h22);
        c4 = pkt(3'd0, 40'h23);
        ch_valid = 4'b1111;
        tick();
        ch_valid = 4'b0111;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("t4_lose", 64'(grant_id == 2'd3), 64'd0);
        end
        tick();
        chk("t4_aged_win", 64'(grant_id), 64'd3);
        chk("t4_aged_data", 64'(out_data), 64'(pkt(3'd0, 40'h23)));
        ch_valid = 4'b0000;
        drain_wait("t4_drain");
        chk("t4_count", 64'(pkt_count), 64'd35);

        // Downstream stall with all channels full
        out_ready = 1'b0;
        c1 = pkt(3'd5, 40'h31);
        c2 = pkt(3'd6, 40'h32);
        c3 = pkt(3'd5, 40'h33);
        c4 = pkt(3'd7, 40'h34);
        ch_valid = 4'b1111;
        tick();
        tick();
        chk("t5_first_grant", 64'(grant_id), 64'd3);
        c4 = pkt(3'd5, 40'h35);
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("t5_stall_data", 64'(out_data), 64'(pkt(3'd7, 40'h34)));
            chk("t5_stall_ready", 64'(ch_ready), 64'h0);
            tick();
        end
        ch_valid = 4'b0000;
        out_ready = 1'b1;
        tick();
        chk("t5_drain_g1", 64'(grant_id), 64'd1);
        chk("t5_drain_d1", 64'(out_data), 64'(pkt(3'd6, 40'h32)));
        tick();
        chk("t5_drain_g2", 64'(grant_id), 64'd2);
        tick();
        chk("t5_drain_g3", 64'(grant_id), 64'd3);
        chk("t5_drain_d3", 64'(out_data), 64'(pkt(3'd5, 40'h35)));
        tick();
        chk("t5_drain_g4", 64'(grant_id), 64'd0);
        chk("t5_drain_v4", 64'(out_valid), 64'd1);
        tick();
        chk("t5_idle", 64'(out_valid), 64'd0);
        chk("t5_count", 64'(pkt_count), 64'd40);

        // Reset mid-transfer
        out_ready = 1'b0;
        ch_valid = 4'b1111;
        tick();
        tick();
        tick();
        chk("t6_pre_valid", 64'(out_valid), 64'd1);
        chk("t6_pre_ready", 64'(ch_ready), 64'h0);
        rst = 1'b0;
        #1;
        ch_valid = 4'b0000;
        out_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_ready", 64'(ch_ready), 64'hf);
        chk("t6_rst_count", 64'(pkt_count), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_no_replay", 64'(out_valid), 64'd0);
        end
        chk("t6_count_after", 64'(pkt_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
